// File: rtl/subtractor_pkg.sv
// subtractor_pkg: shared state encoding and default width for the serial subtractor.
// Revision 1.0
`default_nettype none

package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if: start/operand request and result bundle of the serial subtractor.
// Revision 1.0
`default_nettype none

interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = subtractor_pkg::SUB_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

`default_nettype wire

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit subtract cell, a - b - bin.
// Revision 1.0
`default_nettype none

module full_subtractor (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      diff,
  output logic      bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: computes a - b - bin one bit per clock, LSB first, through a single cell.
// Revision 1.0
`default_nettype none

module serial_subtractor_ctrl
  import subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  wire logic                clk,
  input  wire logic                rst,
  serial_subtractor_ctrl_if.slave  bus
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic [KW-1:0]    r_k;
  logic             w_cell_diff;
  logic             w_cell_bout;
  logic             w_last;

  full_subtractor u_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_br),
    .diff (w_cell_diff),
    .bout (w_cell_bout)
  );

  assign w_last = (r_k == K_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_k    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sa <= bus.a;
            r_sb <= bus.b;
            r_br <= bus.bin;
            r_k  <= '0;
          end
        end
        RUN: begin
          r_diff <= {w_cell_diff, r_diff[WIDTH-1:1]};
          r_br   <= w_cell_bout;
          r_sa   <= r_sa >> 1;
          r_sb   <= r_sb >> 1;
          // Counter saturates at the last bit instead of wrapping.
          if (w_last) begin
            r_bout <= w_cell_bout;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed vectors, randomized ops against an arithmetic model, and corner sequences.
`default_nettype none

module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

  serial_subtractor_ctrl #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_diff(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int unsigned r;
    r = (int'(a) - int'(b) - int'(bin)) & ((1 << W) - 1);
    return r[W-1:0];
  endfunction

  function automatic logic model_bout(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    return int'(a) < int'(b) + int'(bin);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from the start cycle through one cycle after done; optional ignored start at cycle 4.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic ignore_start);
    logic [W-1:0] ed;
    logic         eb;
    ed = model_diff(a, b, bin);
    eb = model_bout(a, b, bin);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    tick();
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
    for (int i = 1; i <= W; i++) begin
      check("busy_run", {31'd0, bus.busy}, 32'd1);
      check("done_run", {31'd0, bus.done}, 32'd0);
      if (ignore_start && i == 4) begin
        bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    check("busy_done", {31'd0, bus.busy}, 32'd0);
    check("diff", {24'd0, bus.diff}, {24'd0, ed});
    check("bout", {31'd0, bus.bout}, {31'd0, eb});
    tick();
    check("done_after", {31'd0, bus.done}, 32'd0);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("diff_hold", {24'd0, bus.diff}, {24'd0, ed});
    check("bout_hold", {31'd0, bus.bout}, {31'd0, eb});
    if (ignore_start) begin
      tick();
      check("no_second_op", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  vec_t vecs [7];
  logic [W-1:0] qa [30];
  logic [W-1:0] qb [30];
  logic         qc [30];

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1};
    vecs[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_diff", {24'd0, bus.diff}, 32'd0);
    check("rst_bout", {31'd0, bus.bout}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed table: operands, then the constant expectations in the table itself.
    for (int i = 0; i < 7; i++) begin
      bus.start = 1'b1; bus.a = vecs[i].a; bus.b = vecs[i].b; bus.bin = vecs[i].bin;
      tick();
      bus.start = 1'b0;
      repeat (W) tick();
      check("vec_done", {31'd0, bus.done}, 32'd1);
      check("vec_diff", {24'd0, bus.diff}, {24'd0, vecs[i].exp_diff});
      check("vec_bout", {31'd0, bus.bout}, {31'd0, vecs[i].exp_bout});
      tick();
    end

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'h33, 8'h77, 1'b1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Back-to-back with start held and operands changing every cycle.
    for (int c = 0; c < 30; c++) begin
      qa[c] = W'($urandom); qb[c] = W'($urandom); qc[c] = 1'($urandom);
      bus.start = 1'b1; bus.a = qa[c]; bus.b = qb[c]; bus.bin = qc[c];
      tick();
      if ((c + 1) % 10 == 9) begin
        check("b2b_done", {31'd0, bus.done}, 32'd1);
        check("b2b_diff", {24'd0, bus.diff}, {24'd0, model_diff(qa[c-8], qb[c-8], qc[c-8])});
        check("b2b_bout", {31'd0, bus.bout}, {31'd0, model_bout(qa[c-8], qb[c-8], qc[c-8])});
      end else begin
        check("b2b_no_done", {31'd0, bus.done}, 32'd0);
      end
    end
    bus.start = 1'b0;
    tick();
    check("b2b_idle", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a run after a result with bout=1 is on the outputs.
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h01; bus.bin = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_diff", {24'd0, bus.diff}, 32'd0);
    check("midrst_bout", {31'd0, bus.bout}, 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("midrst_no_done", {31'd0, bus.done}, 32'd0);
    end
    run_op(8'hC8, 8'h64, 1'b1, 1'b0);

    // Reset and start in the same cycle: reset wins.
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("rst_start_busy2", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial subtraction controller. It computes `a - b - bin` over `WIDTH` bits by sequencing a single `full_subtractor` cell one bit per clock, LSB first. It latches the operands on a start handshake, walks the borrow through a register, and reports the difference and final borrow with a one-cycle `done` pulse. It trades latency for area wherever a multi-bit subtract is needed but a ripple array is too large.

## Interface
**Parameters**
- `WIDTH`, 8: operand and result width in bits. Legal range is 2 or more.

**Ports**
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request to begin an operation. Sampled only in IDLE.
- `a`  in  WIDTH: minuend. Captured in the start cycle.
- `b`  in  WIDTH: subtrahend. Captured in the start cycle.
- `bin`  in  1: borrow-in. Captured in the start cycle.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; results are valid.
- `diff`  out  WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1: final borrow. 1 when `a < b + bin` (unsigned).

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - If `start=1`, copy `a` and `b` into shift registers `sa` and `sb`, copy `bin` into borrow register `br`, clear bit counter `k`, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN (one bit per cycle):**
  - Cell inputs are A=`sa[0]`, B=`sb[0]`, Cin=`br`.
  - On each edge: shift the cell Diff into the MSB of the `diff` shift register (right shift), load Bout into `br`, right-shift `sa` and `sb`, and increment `k`.
  - When `k == WIDTH-1` on an edge, go to DONE.
- **DONE:**
  - `done=1` for exactly one cycle, `bout=br`, then go unconditionally to IDLE.
- **Result holding:** `diff` and `bout` hold their values in IDLE until the next accepted start.
- **Ignored starts:** `start` in RUN or DONE is ignored, not queued. Operand changes after the start cycle have no effect.
- **Width rules:**
  - `k` is `$clog2(WIDTH)` bits and never wraps past `WIDTH-1`.
  - Arithmetic is unsigned modulo `2^WIDTH`.
  - `bout` is the only overflow indication.
- **Reset:** reset in any state, including mid-RUN, forces IDLE with outputs at their reset values. The partial result is discarded and no `done` is issued.
- **Priority:** `rst` and `start` high in the same cycle → reset wins and the operation is not started.

## Timing
- **Reset values:** `busy=0`, `done=0`, `diff=0`, `bout=0`; state IDLE, `k=0`, `br=0`.
- **Cycle numbering:** cycle 0 is the edge where `start` is sampled in IDLE.
  - `busy` is high in cycles 1..WIDTH.
  - `done` is high in cycle WIDTH+1.
  - The state is IDLE again in cycle WIDTH+2.
- **Latency:** start to `done` is WIDTH+1 cycles.
- **Throughput:** with `start` held high, one operation per WIDTH+2 cycles. The next start is accepted in the first IDLE cycle.
- **Output validity:** `diff` and `bout` are registered. They are valid from the `done` cycle and stable until `busy` rises again. In RUN, `diff` carries partial bits and is not to be sampled.

## Structure
- **Package `subtractor_pkg`:**
  - state enum `sub_state_t` {IDLE, RUN, DONE};
  - default-width constant `SUB_WIDTH_DEFAULT = 8`.
- **Sub-module:** exactly one instance of the existing `full_subtractor` cell (bit datapath). Its Diff and Bout feed the registers above.
- **Controller:** FSM, counter and shift registers are inline. No further hierarchy.

## Test plan
All scenarios use `WIDTH=8`.
- **Basic subtract:** `a=0x5A`, `b=0x3C`, `bin=0`, start pulse → `busy` high for 8 cycles, `done` on cycle 9, `diff=0x1E`, `bout=0`.
- **Underflow:** `a=0x00`, `b=0x01`, `bin=0` → `diff=0xFF`, `bout=1`. Same operands with `bin=1` → `diff=0xFE`, `bout=1`.
- **Equal operands with borrow-in:** `a=0x10`, `b=0x10`, `bin=1` → `diff=0xFF`, `bout=1`. Same with `bin=0` → `diff=0x00`, `bout=0`.
- **Back-to-back:** `start` held high, operands change every cycle → operations start at cycles 0, 10 and 20. Each result matches the operands present at its start cycle, and `done` pulses at cycles 9, 19 and 29.
- **Ignored start:** `start` pulse at cycle 4 of a run with new operands → no effect. Original result at cycle 9, and no second operation.
- **Reset mid-run:** `rst` at cycle 5 → next cycle `busy=0`, `diff=0`, `bout=0`, and no `done`. A fresh start afterwards produces the correct result on schedule.
